// File: rtl/arbiter_x4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: state encoding,
// requester count, default hold limit and a one-hot helper.
package arbiter_x4_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam int N_REQ            = 4;
   localparam int HOLD_MAX_DEFAULT = 15;

   function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/arbiter_x4_prio_enc.sv
// 4-input / 2-output priority encoder: the highest set input wins, and valid
// flags that at least one input is set.
module arbiter_x4_prio_enc (
   input  logic [3:0] a,
   output logic [1:0] z,
   output logic       valid
);

   always_comb begin
      z = 2'd0;
      if (a[3])      z = 2'd3;
      else if (a[2]) z = 2'd2;
      else if (a[1]) z = 2'd1;
      valid = |a;
   end

endmodule

// File: rtl/arbiter_x4.sv
// Round-robin arbiter for four requesters with registered one-hot grant,
// owner index, and an optional hold limit that revokes long ownerships.
module arbiter_x4
   import arbiter_x4_pkg::*;
#(
   parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [1:0]       last, last_next;
   logic [3:0]       gnt_next;
   logic [1:0]       gnt_id_next;
   logic             timeout_next;

   logic [7:0]       req_dbl;
   logic [3:0]       rot;
   logic [1:0]       enc_k;
   logic             any_req;
   logic [1:0]       win;
   logic             owner_req;
   logic             limit_hit;
   logic             release_now;

   // Rotate so the requester served last lands at bit 0 (lowest priority).
   always_comb begin
      req_dbl   = {req, req} >> last;
      rot       = req_dbl[3:0];
      win       = enc_k + last;
      owner_req = req[gnt_id];
      limit_hit = (HOLD_MAX != 0) && (cnt == CNT_W'(HOLD_MAX));
      release_now = done || !owner_req || limit_hit;
   end

   arbiter_x4_prio_enc u_enc (
      .a     (rot),
      .z     (enc_k),
      .valid (any_req)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         last    <= 2'd0;
         gnt     <= 4'b0000;
         gnt_id  <= 2'd0;
         timeout <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         last    <= last_next;
         gnt     <= gnt_next;
         gnt_id  <= gnt_id_next;
         timeout <= timeout_next;
      end
   end

   // Counter saturates rather than wrapping when the hold limit is disabled.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      last_next  = last;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               state_next = ST_GRANT;
               cnt_next   = CNT_W'(1);
            end
         end
         ST_GRANT: begin
            if (release_now) begin
               state_next = ST_IDLE;
               last_next  = gnt_id;
            end else if (cnt != {CNT_W{1'b1}}) begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt_next     = gnt;
      gnt_id_next  = gnt_id;
      timeout_next = 1'b0;
      case (state)
         ST_IDLE: begin
            gnt_next = 4'b0000;
            if (any_req) begin
               gnt_next    = onehot4(win);
               gnt_id_next = win;
            end
         end
         ST_GRANT: begin
            if (release_now) begin
               gnt_next     = 4'b0000;
               timeout_next = limit_hit && !done && owner_req;
            end
         end
         default: gnt_next = 4'b0000;
      endcase
   end

   assign gnt_valid = |gnt;

endmodule

// File: tb/tb_arbiter_x4.sv
// Bench for arbiter_x4: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_arbiter_x4;

   localparam int HOLD = 4;
   localparam int SAT  = 15;

   logic       clk;
   logic       reset_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int n_cmp = 0;
   int n_bad = 0;
   bit sim_done = 0;

   arbiter_x4 #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: owner index (-1 when idle), cycles held, last served requester.
   int         m_owner = -1;
   int         m_cnt   = 0;
   int         m_last  = 0;
   logic [3:0] m_gnt   = 4'b0000;
   logic [1:0] m_id    = 2'd0;
   logic       m_to    = 1'b0;
   bit         m_found;
   bit         m_rel_other;
   bit         m_rel_lim;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_owner = -1;
         m_cnt   = 0;
         m_last  = 0;
         m_gnt   = 4'b0000;
         m_id    = 2'd0;
         m_to    = 1'b0;
      end else begin
         m_to = 1'b0;
         if (m_owner < 0) begin
            m_found = 0;
            for (int i = 1; i <= 4; i++) begin
               int c;
               c = (m_last + 4 - i) % 4;
               if (!m_found && req[c]) begin
                  m_found = 1;
                  m_owner = c;
               end
            end
            if (m_found) begin
               m_cnt = 1;
               m_id  = 2'(m_owner);
               m_gnt = 4'b0000;
               m_gnt[m_owner] = 1'b1;
            end else begin
               m_gnt = 4'b0000;
            end
         end else begin
            m_rel_other = done || !req[m_owner];
            m_rel_lim   = (HOLD != 0) && (m_cnt == HOLD);
            if (m_rel_other || m_rel_lim) begin
               m_last  = m_owner;
               m_owner = -1;
               m_gnt   = 4'b0000;
               m_to    = !m_rel_other;
            end else if (m_cnt < SAT) begin
               m_cnt = m_cnt + 1;
            end
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_cycle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      while (!sim_done) begin
         @(negedge clk);
         check_output("cmp_gnt", 32'(gnt), 32'(m_gnt));
         check_output("cmp_gnt_id", 32'(gnt_id), 32'(m_id));
         check_output("cmp_gnt_valid", 32'(gnt_valid), 32'(|m_gnt));
         check_output("cmp_timeout", 32'(timeout), 32'(m_to));
      end
   end

   int order[4] = '{2, 1, 0, 3};

   initial begin
      reset_n = 1'b1;
      req     = 4'b0000;
      done    = 1'b0;
      #1 reset_n = 1'b0;
      req = 4'b1111;
      #2;
      check_output("rst_gnt", 32'(gnt), 32'h0);
      check_output("rst_gnt_id", 32'(gnt_id), 32'h0);
      check_output("rst_valid", 32'(gnt_valid), 32'h0);
      check_output("rst_timeout", 32'(timeout), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      apply_cycle();
      check_output("first_gnt", 32'(gnt), 32'h8);
      check_output("first_gnt_id", 32'(gnt_id), 32'h3);

      // Rotation 3 -> 2 -> 1 -> 0 -> 3, one dead cycle between grants.
      for (int i = 0; i < 4; i++) begin
         done = 1'b1;
         apply_cycle();
         check_output("rot_gap", 32'(gnt), 32'h0);
         done = 1'b0;
         apply_cycle();
         check_output("rot_gnt", 32'(gnt), 32'(4'b0001 << order[i]));
         check_output("rot_gnt_id", 32'(gnt_id), 32'(order[i]));
      end

      // Owner 3 drops its request; with L=3 requester 1 beats 0.
      req = 4'b0011;
      apply_cycle();
      check_output("drop_rel", 32'(gnt), 32'h0);
      apply_cycle();
      check_output("drop_gnt1", 32'(gnt), 32'h2);
      req = 4'b0001;
      apply_cycle();
      check_output("drop_rel2", 32'(gnt), 32'h0);
      apply_cycle();
      check_output("drop_gnt0", 32'(gnt), 32'h1);

      // Hold limit: requester 2 alone is revoked after 4 cycles.
      req = 4'b0100;
      apply_cycle();
      apply_cycle();
      for (int i = 0; i < HOLD; i++) begin
         check_output("hold_gnt", 32'(gnt), 32'h4);
         if (i < HOLD - 1) apply_cycle();
      end
      apply_cycle();
      check_output("hold_rel", 32'(gnt), 32'h0);
      check_output("hold_timeout", 32'(timeout), 32'h1);
      apply_cycle();
      check_output("hold_regrant", 32'(gnt), 32'h4);
      check_output("hold_to_clear", 32'(timeout), 32'h0);

      // done coinciding with the limit suppresses the timeout pulse.
      apply_cycle();
      apply_cycle();
      apply_cycle();
      done = 1'b1;
      apply_cycle();
      check_output("simul_rel", 32'(gnt), 32'h0);
      check_output("simul_timeout", 32'(timeout), 32'h0);
      done = 1'b0;
      apply_cycle();
      check_output("simul_regrant", 32'(gnt), 32'h4);

      // Asynchronous reset mid-grant.
      req = 4'b0010;
      apply_cycle();
      apply_cycle();
      check_output("ar_pre_gnt", 32'(gnt), 32'h2);
      @(negedge clk);
      #1 reset_n = 1'b0;
      req = 4'b1111;
      #1;
      check_output("ar_gnt", 32'(gnt), 32'h0);
      check_output("ar_valid", 32'(gnt_valid), 32'h0);
      check_output("ar_gnt_id", 32'(gnt_id), 32'h0);
      @(negedge clk);
      #1 reset_n = 1'b1;
      apply_cycle();
      check_output("ar_next_gnt", 32'(gnt), 32'h8);
      check_output("ar_next_id", 32'(gnt_id), 32'h3);

      // Randomized traffic, with occasional asynchronous resets.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         done = ($urandom_range(0, 7) == 0);
         if ((cyc % 700) == 699) begin
            @(negedge clk);
            #1 reset_n = 1'b0;
            #1;
            check_output("rand_rst_gnt", 32'(gnt), 32'h0);
            @(negedge clk);
            #1 reset_n = 1'b1;
         end
         apply_cycle();
      end

      sim_done = 1'b1;
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
